// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared constants for the MEM pipeline stage: opcode and funct3 codes
//   for loads/stores, the 2-bit FSM state encodings, and a helper that
//   maps (load/store, funct3) to the index of the last byte to transfer.
package mem_stage_pkg;

  localparam logic [6:0] INST_LOAD  = 7'b0000011;
  localparam logic [6:0] INST_STORE = 7'b0100011;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  localparam logic [1:0] MEM_STATE_IDLE  = 2'd0;
  localparam logic [1:0] MEM_STATE_READ  = 2'd1;
  localparam logic [1:0] MEM_STATE_RWAIT = 2'd2;
  localparam logic [1:0] MEM_STATE_WRITE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = MEM_STATE_IDLE,
    ST_READ  = MEM_STATE_READ,
    ST_RWAIT = MEM_STATE_RWAIT,
    ST_WRITE = MEM_STATE_WRITE
  } mem_state_e;

  // Index of the last byte (N-1). Any funct3 not naming a byte or half
  // access is handled as a full word.
  function automatic logic [1:0] last_byte_idx(input logic is_store,
                                               input logic [2:0] f3);
    logic [1:0] idx;
    idx = 2'd3;
    if (is_store) begin
      case (f3)
        FUNCT3_SB: idx = 2'd0;
        FUNCT3_SH: idx = 2'd1;
        default:   idx = 2'd3;
      endcase
    end else begin
      case (f3)
        FUNCT3_LB, FUNCT3_LBU: idx = 2'd0;
        FUNCT3_LH, FUNCT3_LHU: idx = 2'd1;
        default:               idx = 2'd3;
      endcase
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// mem_stage_load_extend
//   Combinational sign/zero extension of an assembled little-endian load.
//   raw_i    : assembled bytes, byte k in raw_i[8k+7:8k]
//   funct3_i : load width/signedness
//   data_o   : extended 32-bit result (unknown funct3 passes the word through)
module mem_stage_load_extend
  import mem_stage_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = raw_i;
    case (funct3_i)
      FUNCT3_LB:  data_o = {{24{raw_i[7]}}, raw_i[7:0]};
      FUNCT3_LBU: data_o = {24'h0, raw_i[7:0]};
      FUNCT3_LH:  data_o = {{16{raw_i[15]}}, raw_i[15:0]};
      FUNCT3_LHU: data_o = {16'h0, raw_i[15:0]};
      default:    data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
//   Pipeline MEM stage. Accepts an EX bundle when idle, performs byte-serial
//   loads/stores over a single byte-wide RAM port (1-cycle read latency),
//   and emits a registered one-cycle writeback pulse.
//   Ports:
//     clk, rst                    : clock, async active-high reset
//     ex_valid_i / ex_ready_o     : EX handshake (ready == idle)
//     wd_i, wreg_i, wdata_i       : destination reg, write enable, ALU result
//     mem_addr_i, store_data_i    : effective byte address, store value
//     inst_i                      : instruction (opcode, funct3 used)
//     mem_din_i                   : RAM read byte
//     mem_dout_o, mem_a_o, mem_wr_o : RAM write byte, address, write strobe
//     wb_valid_o, wd_o, wreg_o, wdata_o : writeback bundle
//     stall_req_o                 : busy, to pipeline control
//
//   state  | meaning
//   IDLE   | ready for a bundle; ALU results retire from here in one cycle
//   READ   | presenting load address addr+idx, capturing byte idx-1
//   RWAIT  | capturing last load byte, writing back the extended result
//   WRITE  | strobing store byte idx to addr+idx
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid_i,
  output logic                      ex_ready_o,
  input  logic [REG_ADDR_WIDTH-1:0] wd_i,
  input  logic                      wreg_i,
  input  logic [31:0]               wdata_i,
  input  logic [ADDR_WIDTH-1:0]     mem_addr_i,
  input  logic [31:0]               store_data_i,
  input  logic [31:0]               inst_i,
  input  logic [7:0]                mem_din_i,
  output logic [7:0]                mem_dout_o,
  output logic [ADDR_WIDTH-1:0]     mem_a_o,
  output logic                      mem_wr_o,
  output logic                      wb_valid_o,
  output logic [REG_ADDR_WIDTH-1:0] wd_o,
  output logic                      wreg_o,
  output logic [31:0]               wdata_o,
  output logic                      stall_req_o
);

  mem_state_e                state_q;
  logic [1:0]                idx_q;
  logic [1:0]                last_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [3:0][7:0]           sdata_q;
  logic [3:0][7:0]           raw_q;
  logic [2:0]                funct3_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic                      rd_wreg_q;

  logic                      wb_valid_q;
  logic [REG_ADDR_WIDTH-1:0] wd_q;
  logic                      wreg_q;
  logic [31:0]               wdata_q;

  logic [6:0]                opcode;
  logic [2:0]                funct3;
  logic [3:0][7:0]           raw_full;
  logic [31:0]               load_word;
  logic                      unused_inst_bits;

  assign opcode           = inst_i[6:0];
  assign funct3           = inst_i[14:12];
  assign unused_inst_bits = ^{inst_i[31:15], inst_i[11:7]};

  // In RWAIT the last byte is still on mem_din_i; merge it so the
  // extended result can be registered in the same cycle.
  always_comb begin
    raw_full         = raw_q;
    raw_full[last_q] = mem_din_i;
  end

  mem_stage_load_extend u_load_extend (
    .raw_i    (raw_full),
    .funct3_i (funct3_q),
    .data_o   (load_word)
  );

  // RAM port is driven from state so reset removes the strobe at once.
  always_comb begin
    mem_wr_o   = 1'b0;
    mem_a_o    = '0;
    mem_dout_o = '0;
    if (state_q == ST_READ || state_q == ST_WRITE) begin
      mem_a_o = addr_q + ADDR_WIDTH'(idx_q);
    end
    if (state_q == ST_WRITE) begin
      mem_wr_o   = 1'b1;
      mem_dout_o = sdata_q[idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      last_q     <= '0;
      addr_q     <= '0;
      sdata_q    <= '0;
      raw_q      <= '0;
      funct3_q   <= '0;
      rd_q       <= '0;
      rd_wreg_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      wd_q       <= '0;
      wreg_q     <= 1'b0;
      wdata_q    <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ex_valid_i) begin
            addr_q    <= mem_addr_i;
            sdata_q   <= store_data_i;
            funct3_q  <= funct3;
            rd_q      <= wd_i;
            rd_wreg_q <= wreg_i;
            raw_q     <= '0;
            idx_q     <= '0;
            if (opcode == INST_LOAD) begin
              state_q <= ST_READ;
              last_q  <= last_byte_idx(1'b0, funct3);
            end else if (opcode == INST_STORE) begin
              state_q <= ST_WRITE;
              last_q  <= last_byte_idx(1'b1, funct3);
            end else begin
              wb_valid_q <= 1'b1;
              wd_q       <= wd_i;
              wreg_q     <= wreg_i && (wd_i != '0);
              wdata_q    <= wdata_i;
            end
          end
        end
        ST_READ: begin
          // Byte for the previous address arrives one cycle late.
          if (idx_q != 2'd0) begin
            raw_q[idx_q - 2'd1] <= mem_din_i;
          end
          if (idx_q == last_q) begin
            state_q <= ST_RWAIT;
          end else begin
            idx_q <= idx_q + 2'd1;
          end
        end
        ST_RWAIT: begin
          state_q    <= ST_IDLE;
          wb_valid_q <= 1'b1;
          wd_q       <= rd_q;
          wreg_q     <= rd_wreg_q && (rd_q != '0);
          wdata_q    <= load_word;
        end
        ST_WRITE: begin
          if (idx_q == last_q) begin
            state_q    <= ST_IDLE;
            wb_valid_q <= 1'b1;
            wd_q       <= rd_q;
            wreg_q     <= 1'b0;
          end else begin
            idx_q <= idx_q + 2'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ex_ready_o  = (state_q == ST_IDLE);
  assign stall_req_o = (state_q != ST_IDLE);
  assign wb_valid_o  = wb_valid_q;
  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign wdata_o     = wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [31:0] mem_addr_i;
  logic [31:0] store_data_i;
  logic [31:0] inst_i;
  logic [7:0]  mem_din_i;
  logic [7:0]  mem_dout_o;
  logic [31:0] mem_a_o;
  logic        mem_wr_o;
  logic        wb_valid_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req_o;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] ram [logic [31:0]];

  always #5 clk = ~clk;

  mem_stage #(.ADDR_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid_i   (ex_valid_i),
    .ex_ready_o   (ex_ready_o),
    .wd_i         (wd_i),
    .wreg_i       (wreg_i),
    .wdata_i      (wdata_i),
    .mem_addr_i   (mem_addr_i),
    .store_data_i (store_data_i),
    .inst_i       (inst_i),
    .mem_din_i    (mem_din_i),
    .mem_dout_o   (mem_dout_o),
    .mem_a_o      (mem_a_o),
    .mem_wr_o     (mem_wr_o),
    .wb_valid_o   (wb_valid_o),
    .wd_o         (wd_o),
    .wreg_o       (wreg_o),
    .wdata_o      (wdata_o),
    .stall_req_o  (stall_req_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Unwritten RAM locations hold a random but stable byte.
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (!ram.exists(a)) ram[a] = 8'($urandom);
    return ram[a];
  endfunction

  function automatic int n_bytes(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
  endfunction

  function automatic logic [31:0] load_expect(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] w;
    logic [31:0] b;
    logic [31:0] h;
    w = 0;
    for (int k = 0; k < 4; k++) w = w + (32'(ram_rd(addr + 32'(k))) << (8 * k));
    b = w % 256;
    h = w % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // Garbage on the EX side while busy; the stage must ignore it.
  task automatic junk_ex();
    ex_valid_i   = 1'($urandom);
    inst_i       = $urandom;
    wd_i         = 5'($urandom);
    wreg_i       = 1'($urandom);
    wdata_i      = $urandom;
    mem_addr_i   = $urandom;
    store_data_i = $urandom;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    chk("idle_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("idle_stall", 32'(stall_req_o), 32'd0);
    chk("idle_ready", 32'(ex_ready_o), 32'd1);
    chk("idle_mem_wr", 32'(mem_wr_o), 32'd0);
    chk("idle_mem_a", mem_a_o, 32'd0);
  endtask

  // Starts at a negedge with the stage idle; returns at the negedge of the
  // writeback cycle so the next call can be accepted back-to-back.
  task automatic run_txn(input logic [6:0] opc, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [4:0] wd,
                         input logic wreg, input logic [31:0] wdat,
                         input logic [31:0] sdat);
    int n;
    logic [31:0] prev_a;
    logic [31:0] inst;
    logic [31:0] exp_w;
    chk("accept_ready", 32'(ex_ready_o), 32'd1);
    inst         = $urandom;
    inst[6:0]    = opc;
    inst[14:12]  = f3;
    ex_valid_i   = 1'b1;
    inst_i       = inst;
    wd_i         = wd;
    wreg_i       = wreg;
    wdata_i      = wdat;
    mem_addr_i   = addr;
    store_data_i = sdat;
    prev_a       = 32'd0;
    @(negedge clk);
    if (opc == OP_LOAD) begin
      n = n_bytes(1'b0, f3);
      for (int k = 0; k < n; k++) begin
        mem_din_i = ram_rd(prev_a);
        prev_a    = mem_a_o;
        chk("ld_addr", mem_a_o, addr + 32'(k));
        chk("ld_mem_wr", 32'(mem_wr_o), 32'd0);
        chk("ld_stall", 32'(stall_req_o), 32'd1);
        chk("ld_ready", 32'(ex_ready_o), 32'd0);
        chk("ld_wb_valid", 32'(wb_valid_o), 32'd0);
        junk_ex();
        @(negedge clk);
      end
      mem_din_i = ram_rd(prev_a);
      chk("rwait_stall", 32'(stall_req_o), 32'd1);
      chk("rwait_wb_valid", 32'(wb_valid_o), 32'd0);
      chk("rwait_mem_a", mem_a_o, 32'd0);
      junk_ex();
      @(negedge clk);
      exp_w = load_expect(f3, addr);
      chk("ld_wb_valid_pulse", 32'(wb_valid_o), 32'd1);
      chk("ld_wdata", wdata_o, exp_w);
      chk("ld_wd", 32'(wd_o), 32'(wd));
      chk("ld_wreg", 32'(wreg_o), 32'(wreg && (wd != 0)));
      chk("ld_done_stall", 32'(stall_req_o), 32'd0);
    end else if (opc == OP_STORE) begin
      n = n_bytes(1'b1, f3);
      for (int k = 0; k < n; k++) begin
        chk("st_mem_wr", 32'(mem_wr_o), 32'd1);
        chk("st_addr", mem_a_o, addr + 32'(k));
        chk("st_dout", 32'(mem_dout_o), (sdat >> (8 * k)) % 256);
        chk("st_stall", 32'(stall_req_o), 32'd1);
        chk("st_wb_valid", 32'(wb_valid_o), 32'd0);
        ram[addr + 32'(k)] = 8'((sdat >> (8 * k)) % 256);
        junk_ex();
        @(negedge clk);
      end
      chk("st_wb_valid_pulse", 32'(wb_valid_o), 32'd1);
      chk("st_wreg", 32'(wreg_o), 32'd0);
      chk("st_done_mem_wr", 32'(mem_wr_o), 32'd0);
      chk("st_done_stall", 32'(stall_req_o), 32'd0);
    end else begin
      chk("alu_wb_valid", 32'(wb_valid_o), 32'd1);
      chk("alu_wd", 32'(wd_o), 32'(wd));
      chk("alu_wreg", 32'(wreg_o), 32'(wreg && (wd != 0)));
      chk("alu_wdata", wdata_o, wdat);
      chk("alu_mem_wr", 32'(mem_wr_o), 32'd0);
      chk("alu_stall", 32'(stall_req_o), 32'd0);
    end
    ex_valid_i = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(ex_ready_o), 32'd1);
    chk({tag, "_stall"}, 32'(stall_req_o), 32'd0);
    chk({tag, "_wb_valid"}, 32'(wb_valid_o), 32'd0);
    chk({tag, "_wd"}, 32'(wd_o), 32'd0);
    chk({tag, "_wreg"}, 32'(wreg_o), 32'd0);
    chk({tag, "_wdata"}, wdata_o, 32'd0);
    chk({tag, "_mem_wr"}, 32'(mem_wr_o), 32'd0);
    chk({tag, "_mem_a"}, mem_a_o, 32'd0);
    chk({tag, "_mem_dout"}, 32'(mem_dout_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [6:0]  opc;
    logic [31:0] addr;
    int          r;

    rst = 1'b1;
    ex_valid_i = 1'b0; wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
    mem_addr_i = '0; store_data_i = '0; inst_i = '0; mem_din_i = '0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    idle_cycle();

    // ALU op
    run_txn(OP_ALU, 3'd0, 32'h0, 5'd5, 1'b1, 32'h0000_1234, 32'h0);
    idle_cycle();

    // LW with known bytes
    ram[32'h100] = 8'h78; ram[32'h101] = 8'h56; ram[32'h102] = 8'h34; ram[32'h103] = 8'h12;
    run_txn(OP_LOAD, 3'd2, 32'h100, 5'd3, 1'b1, 32'h0, 32'h0);
    chk("lw_known_value", wdata_o, 32'h1234_5678);
    idle_cycle();

    // Sign/zero extension
    ram[32'h300] = 8'h80; ram[32'h301] = 8'h80;
    run_txn(OP_LOAD, 3'd0, 32'h300, 5'd4, 1'b1, 32'h0, 32'h0);
    chk("lb_known_value", wdata_o, 32'hFFFF_FF80);
    run_txn(OP_LOAD, 3'd4, 32'h300, 5'd4, 1'b1, 32'h0, 32'h0);
    chk("lbu_known_value", wdata_o, 32'h0000_0080);
    run_txn(OP_LOAD, 3'd1, 32'h300, 5'd4, 1'b1, 32'h0, 32'h0);
    chk("lh_known_value", wdata_o, 32'hFFFF_8080);
    ram[32'h310] = 8'h01; ram[32'h311] = 8'h80;
    run_txn(OP_LOAD, 3'd5, 32'h310, 5'd4, 1'b1, 32'h0, 32'h0);
    chk("lhu_known_value", wdata_o, 32'h0000_8001);
    idle_cycle();

    // SH
    run_txn(OP_STORE, 3'd1, 32'h200, 5'd7, 1'b1, 32'h0, 32'hAABB_CCDD);
    idle_cycle();
    run_txn(OP_LOAD, 3'd1, 32'h200, 5'd8, 1'b1, 32'h0, 32'h0);
    chk("sh_readback", wdata_o, 32'hFFFF_CCDD);

    // Address wrap and wd == 0
    run_txn(OP_LOAD, 3'd2, 32'hFFFF_FFFE, 5'd9, 1'b1, 32'h0, 32'h0);
    run_txn(OP_LOAD, 3'd2, 32'h100, 5'd0, 1'b1, 32'h0, 32'h0);
    run_txn(OP_ALU, 3'd0, 32'h0, 5'd0, 1'b1, 32'hDEAD_BEEF, 32'h0);
    idle_cycle();

    // Reset in the middle of a SW
    chk("rst_sw_ready", 32'(ex_ready_o), 32'd1);
    ex_valid_i = 1'b1; inst_i = {17'h0, 3'd2, 5'h0, OP_STORE};
    mem_addr_i = 32'h400; store_data_i = 32'h1122_3344; wd_i = 5'd1; wreg_i = 1'b1;
    @(negedge clk);
    ex_valid_i = 1'b0;
    chk("rst_sw_b0_wr", 32'(mem_wr_o), 32'd1);
    chk("rst_sw_b0_a", mem_a_o, 32'h400);
    chk("rst_sw_b0_d", 32'(mem_dout_o), 32'h44);
    ram[32'h400] = 8'h44;
    @(negedge clk);
    chk("rst_sw_b1_a", mem_a_o, 32'h401);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    run_txn(OP_ALU, 3'd0, 32'h0, 5'd6, 1'b1, 32'h0BAD_F00D, 32'h0);
    run_txn(OP_LOAD, 3'd2, 32'h400, 5'd6, 1'b1, 32'h0, 32'h0);
    idle_cycle();

    // Randomized mix
    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 2);
      case (r)
        0: opc = OP_LOAD;
        1: opc = OP_STORE;
        default: begin
          case ($urandom_range(0, 3))
            0: opc = 7'b0110011;
            1: opc = 7'b0010011;
            2: opc = 7'b0110111;
            default: opc = 7'b1100011;
          endcase
        end
      endcase
      if ($urandom_range(0, 3) == 0) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else addr = 32'h1000 + 32'($urandom_range(0, 63));
      run_txn(opc, 3'($urandom_range(0, 7)), addr, 5'($urandom),
              1'($urandom), $urandom, $urandom);
      for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
